histo_run_ctrl: RTL and testbench

//  Sequences acquisition runs for the per-channel hit histogram counters.

---
 rtl/histo_ctrl_pkg.sv | 16 +
 rtl/histo_run_ctrl_if.sv | 12 +
 rtl/histo_readout_mux.sv | 84 ++++++++
 rtl/histo_run_ctrl.sv | 133 +++++++++++++
 tb/tb_histo_run_ctrl.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/histo_ctrl_pkg.sv
// Shared types and constants for the histogram run controller.
package histo_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      ACQ   = 3'd2,
      DRAIN = 3'd3,
      SNAP  = 3'd4,
      READ  = 3'd5
   } state_t;

   localparam logic [7:0] HDR_CHAN = 8'hFF;
   localparam int         CW_DEF   = 32;

endpackage

// File: rtl/histo_run_ctrl_if.sv
// Readout stream: one word per accepted valid/ready beat, tagged with its channel.
interface histo_run_ctrl_if #(parameter int CW = histo_ctrl_pkg::CW_DEF);

   logic [CW-1:0] out_data;
   logic [7:0]    out_chan;
   logic          out_valid;
   logic          out_ready;

   modport master (output out_data, output out_chan, output out_valid, input out_ready);
   modport slave  (input out_data, input out_chan, input out_valid, output out_ready);

endinterface

// File: rtl/histo_readout_mux.sv
// Snapshot bank and readout stream for the run controller.
// HISTO_RUN_HEADER_EN: prefix each readout with a run-number header word.
module histo_readout_mux
   import histo_ctrl_pkg::*;
#(
   parameter int NCH = 2,
   parameter int CW  = CW_DEF
) (
   input  logic              clkin,
   input  logic              reset,
   input  logic              snap,
   input  logic              flush,
   input  logic [NCH*CW-1:0] histo_in,
   output logic              last_acc,
   histo_run_ctrl_if.master  rd
);

`ifdef HISTO_RUN_HEADER_EN
   localparam int HDR = 1;
   logic [CW-1:0] run_cnt;
   localparam logic [CW-1:0] ONE = CW'(1);
`else
   localparam int HDR = 0;
`endif
   localparam int         NW      = NCH + HDR;
   localparam logic [7:0] LAST    = 8'(NW - 1);
   localparam logic [7:0] HDR_OFS = 8'(HDR);

   logic [CW-1:0] snap_r [NCH];
   logic [7:0]    idx;
   logic [7:0]    nxt_idx;
   logic [CW-1:0] nxt_data;
   logic          acc;

   assign acc      = rd.out_valid && rd.out_ready;
   assign last_acc = acc && (idx == LAST);

   always_comb begin
      nxt_idx  = idx + 8'd1;
      nxt_data = '0;
      for (int c = 0; c < NCH; c++) begin
         if (8'(c + HDR) == nxt_idx) nxt_data = snap_r[c];
      end
   end

   // Output word is registered so data/chan cannot move while the consumer stalls.
   always_ff @(posedge clkin) begin
      if (reset) begin
         rd.out_valid <= 1'b0;
         rd.out_data  <= '0;
         rd.out_chan  <= '0;
         idx          <= '0;
         for (int c = 0; c < NCH; c++) snap_r[c] <= '0;
`ifdef HISTO_RUN_HEADER_EN
         run_cnt      <= '0;
`endif
      end else if (flush) begin
         rd.out_valid <= 1'b0;
      end else if (snap) begin
         for (int c = 0; c < NCH; c++) snap_r[c] <= histo_in[c*CW +: CW];
         idx          <= '0;
         rd.out_valid <= 1'b1;
`ifdef HISTO_RUN_HEADER_EN
         rd.out_data  <= run_cnt;
         rd.out_chan  <= HDR_CHAN;
`else
         rd.out_data  <= histo_in[CW-1:0];
         rd.out_chan  <= 8'd0;
`endif
      end else if (acc) begin
         if (idx == LAST) begin
            rd.out_valid <= 1'b0;
`ifdef HISTO_RUN_HEADER_EN
            run_cnt      <= run_cnt + ONE;
`endif
         end else begin
            idx         <= nxt_idx;
            rd.out_data <= nxt_data;
            rd.out_chan <= nxt_idx - HDR_OFS;
         end
      end
   end

endmodule

// File: rtl/histo_run_ctrl.sv
// Acquisition run sequencer: clear, gated window, drain, snapshot, stream readout.
// Optional header word (HISTO_RUN_HEADER_EN) is handled in histo_readout_mux.
//
// state | meaning
// IDLE  | waiting for start
// CLEAR | hist_clear for CLR_CYC cycles, then PIPE_DLY cycles for the clear to land
// ACQ   | hist_gate high for win_r cycles
// DRAIN | gate low, PIPE_DLY cycles for last gated hits to reach the counters
// SNAP  | one cycle, counts captured into the snapshot bank
// READ  | streaming words until the last one is accepted
module histo_run_ctrl
   import histo_ctrl_pkg::*;
#(
   parameter int NCH      = 2,
   parameter int CW       = CW_DEF,
   parameter int CLR_CYC  = 2,
   parameter int PIPE_DLY = 2
) (
   input  logic              clkin,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic              continuous,
   input  logic [CW-1:0]     window_len,
   input  logic [NCH*CW-1:0] histo_in,
   output logic              hist_clear,
   output logic              hist_gate,
   output logic              busy,
   output logic              done,
   histo_run_ctrl_if.master  rd
);

   localparam logic [CW-1:0] ONE    = CW'(1);
   localparam logic [CW-1:0] CLR_LD = CW'(CLR_CYC + PIPE_DLY - 1);
   localparam logic [CW-1:0] PIPE_K = CW'(PIPE_DLY);
   localparam logic [CW-1:0] DRN_LD = (PIPE_DLY > 0) ? CW'(PIPE_DLY - 1) : '0;

   state_t        state, state_nxt;
   logic [CW-1:0] tmr, tmr_nxt;
   logic [CW-1:0] win_r;
   logic          snap;
   logic          last_acc;

   always_ff @(posedge clkin) begin
      if (reset) begin
         state <= IDLE;
         tmr   <= '0;
         win_r <= '0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         tmr   <= tmr_nxt;
         done  <= last_acc && !abort;
         if (state == IDLE && start && !abort) win_r <= window_len;
      end
   end

   // One shared down-counter times every phase; each phase ends at terminal count zero.
   always_comb begin
      state_nxt  = state;
      tmr_nxt    = tmr;
      hist_clear = 1'b0;
      hist_gate  = 1'b0;
      snap       = 1'b0;
      case (state)
         IDLE: begin
            if (start && !abort) begin
               state_nxt = CLEAR;
               tmr_nxt   = CLR_LD;
            end
         end
         CLEAR: begin
            hist_clear = (tmr >= PIPE_K);
            if (tmr != '0) begin
               tmr_nxt = tmr - ONE;
            end else if (win_r == '0) begin
               state_nxt = DRAIN;
               tmr_nxt   = DRN_LD;
            end else begin
               state_nxt = ACQ;
               tmr_nxt   = win_r - ONE;
            end
         end
         ACQ: begin
            hist_gate = 1'b1;
            if (tmr != '0) begin
               tmr_nxt = tmr - ONE;
            end else begin
               state_nxt = DRAIN;
               tmr_nxt   = DRN_LD;
            end
         end
         DRAIN: begin
            if (tmr != '0) tmr_nxt = tmr - ONE;
            else           state_nxt = SNAP;
         end
         SNAP: begin
            snap      = 1'b1;
            state_nxt = READ;
         end
         READ: begin
            if (last_acc) begin
               state_nxt = continuous ? CLEAR : IDLE;
               tmr_nxt   = continuous ? CLR_LD : '0;
            end
         end
         default: begin
            state_nxt = IDLE;
            tmr_nxt   = '0;
         end
      endcase
      if (abort && state != IDLE) begin
         state_nxt = IDLE;
         tmr_nxt   = '0;
      end
   end

   assign busy = (state != IDLE);

   histo_readout_mux #(
      .NCH (NCH),
      .CW  (CW)
   ) u_readout (
      .clkin    (clkin),
      .reset    (reset),
      .snap     (snap),
      .flush    (abort),
      .histo_in (histo_in),
      .last_acc (last_acc),
      .rd       (rd)
   );

endmodule

// File: tb/tb_histo_run_ctrl.sv
// Bench for histo_run_ctrl: counter model with 2-cycle latency, table of runs, scoreboard readout.
module tb_histo_run_ctrl;
   import histo_ctrl_pkg::*;

   localparam int NCH = 2, CW = 32, CLR_CYC = 2, PIPE_DLY = 2;

   logic              clkin = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0, continuous = 1'b0;
   logic [CW-1:0]     window_len = '0;
   logic [NCH*CW-1:0] histo_in;
   logic              hist_clear, hist_gate, busy, done;

   histo_run_ctrl_if #(.CW(CW)) rd();

   histo_run_ctrl #(.NCH(NCH), .CW(CW), .CLR_CYC(CLR_CYC), .PIPE_DLY(PIPE_DLY)) dut (
      .clkin(clkin), .reset(reset), .start(start), .abort(abort), .continuous(continuous),
      .window_len(window_len), .histo_in(histo_in), .hist_clear(hist_clear),
      .hist_gate(hist_gate), .busy(busy), .done(done), .rd(rd));

   always #5 clkin = ~clkin;

   // Counter datapath model: gate/clear reach the counters two cycles late.
   logic [CW-1:0] cnt0 = '0, cnt1 = '0;
   logic [1:0]    g1 = 2'b00, g2 = 2'b00;
   logic          c1 = 1'b0, c2 = 1'b0, hit0 = 1'b0, hit1 = 1'b0;
   always @(posedge clkin) begin
      g1 <= (hist_gate === 1'b1) ? {hit1, hit0} : 2'b00;
      g2 <= g1;
      c1 <= (hist_clear === 1'b1);
      c2 <= c1;
      if (c2) begin
         cnt0 <= '0;
         cnt1 <= '0;
      end else begin
         if (g2[0]) cnt0 <= cnt0 + 1;
         if (g2[1]) cnt1 <= cnt1 + 1;
      end
   end
   assign histo_in = {cnt1, cnt0};

   typedef struct { logic [7:0] chan; logic [31:0] data; bit last; } exp_t;
   typedef struct { int win; bit h0; bit h1; int stall; logic [31:0] e0; logic [31:0] e1; } vec_t;

   exp_t        sb[$];
   int          n_vec = 0, n_err = 0, done_cnt = 0, stall_left = 0;
   int          gate_cnt = 0, clr_cyc = 0, clr_rises = 0;
   bit          pend_done = 0, prev_stall = 0, gate_q = 0, clr_q = 0, clr_since = 0;
   logic [31:0] held_d, hdr_no = '0;
   logic [7:0]  held_c;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   // Consumer: holds out_ready low for stall_left valid cycles, otherwise accepts.
   initial begin
      rd.out_ready = 1'b1;
      forever begin
         @(posedge clkin);
         #1;
         if (stall_left > 0) begin
            if (rd.out_valid) stall_left--;
            rd.out_ready = 1'b0;
         end else begin
            rd.out_ready = 1'b1;
         end
      end
   end

   always @(negedge clkin) begin
      if (reset) begin
         pend_done = 0;
         prev_stall = 0;
         gate_q = 0;
         clr_q = 0;
      end else begin
         if (done || pend_done) chk("done_timing", 32'(done), 32'(pend_done));
         if (done) done_cnt++;
         pend_done = 0;
         if (prev_stall && rd.out_valid) begin
            chk("stall_hold_data", rd.out_data, held_d);
            chk("stall_hold_chan", 32'(rd.out_chan), 32'(held_c));
         end
         if (rd.out_valid && rd.out_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_word", 32'(rd.out_chan), 32'hFFFF_FFFF);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("word_chan", 32'(rd.out_chan), 32'(e.chan));
               chk("word_data", rd.out_data, e.data);
               pend_done = e.last;
            end
         end
         prev_stall = rd.out_valid && !rd.out_ready;
         held_d = rd.out_data;
         held_c = rd.out_chan;
         if (hist_gate) gate_cnt++;
         if (hist_gate && !gate_q) begin
            chk("clear_before_gate", 32'(clr_since), 32'd1);
            clr_since = 0;
         end
         if (hist_clear) clr_cyc++;
         if (hist_clear && !clr_q) begin
            clr_rises++;
            clr_since = 1;
         end
         gate_q = hist_gate;
         clr_q = hist_clear;
      end
   end

   task automatic push_run(input logic [31:0] e0, input logic [31:0] e1);
`ifdef HISTO_RUN_HEADER_EN
      sb.push_back('{HDR_CHAN, hdr_no, 1'b0});
`endif
      sb.push_back('{8'd0, e0, 1'b0});
      sb.push_back('{8'd1, e1, 1'b1});
      hdr_no = hdr_no + 1;
   endtask

   task automatic pulse_start();
      @(posedge clkin); #1 start = 1'b1;
      @(posedge clkin); #1 start = 1'b0;
   endtask

   task automatic wait_done(input int target, input int budget);
      int k = 0;
      while (done_cnt < target && k < budget) begin
         @(posedge clkin);
         k++;
      end
      chk("done_reached", 32'(done_cnt >= target), 32'd1);
   endtask

   task automatic do_run(input vec_t v);
      int base;
      @(posedge clkin); #1;
      hit0 = v.h0; hit1 = v.h1; window_len = CW'(v.win); stall_left = v.stall;
      push_run(v.e0, v.e1);
      gate_cnt = 0; clr_cyc = 0; clr_rises = 0; base = done_cnt;
      pulse_start();
      wait_done(base + 1, 500);
      @(negedge clkin);
      chk("gate_cycles", 32'(gate_cnt), 32'(v.win));
      chk("clear_cycles", 32'(clr_cyc), 32'(CLR_CYC));
      chk("clear_pulses", 32'(clr_rises), 32'd1);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      chk("idle_after_run", 32'(busy), 32'd0);
   endtask

   vec_t vecs[5];

   initial begin
      int base, k;
      vecs[0] = '{10, 1'b1, 1'b0, 0, 32'd10, 32'd0};
      vecs[1] = '{0,  1'b1, 1'b1, 0, 32'd0,  32'd0};
      vecs[2] = '{7,  1'b1, 1'b1, 5, 32'd7,  32'd7};
      vecs[3] = '{3,  1'b0, 1'b1, 2, 32'd0,  32'd3};
      vecs[4] = '{1,  1'b1, 1'b0, 0, 32'd1,  32'd0};

      repeat (3) @(posedge clkin);
      @(negedge clkin);
      chk("rst_clear", 32'(hist_clear), 32'd0);
      chk("rst_gate", 32'(hist_gate), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_valid", 32'(rd.out_valid), 32'd0);
      chk("rst_data", rd.out_data, 32'd0);
      chk("rst_chan", 32'(rd.out_chan), 32'd0);
      @(posedge clkin); #1 reset = 1'b0;

      for (int i = 0; i < 5; i++) do_run(vecs[i]);

      // abort mid-ACQ: gate drops, no done, counters left as they were
      @(posedge clkin); #1;
      hit0 = 1'b1; hit1 = 1'b0; window_len = 32'd20; gate_cnt = 0; base = done_cnt;
      pulse_start();
      k = 0;
      while (gate_cnt < 5 && k < 100) begin @(posedge clkin); k++; end
      chk("abort_gate_seen", 32'(gate_cnt >= 5), 32'd1);
      #1 abort = 1'b1;
      @(posedge clkin); #1 abort = 1'b0;
      @(negedge clkin);
      chk("abort_gate", 32'(hist_gate), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_valid", 32'(rd.out_valid), 32'd0);
      repeat (20) @(posedge clkin);
      chk("abort_no_done", 32'(done_cnt), 32'(base));
      chk("abort_uncleared", cnt0, 32'(gate_cnt));
      do_run('{10, 1'b1, 1'b0, 0, 32'd10, 32'd0});

      // start and abort together in IDLE
      @(posedge clkin); #1 start = 1'b1; abort = 1'b1;
      @(posedge clkin); #1 start = 1'b0; abort = 1'b0;
      @(negedge clkin);
      chk("start_abort_busy", 32'(busy), 32'd0);
      chk("start_abort_clear", 32'(hist_clear), 32'd0);

      // continuous: three back-to-back runs, last one drops continuous
      @(posedge clkin); #1;
      hit0 = 1'b1; hit1 = 1'b0; window_len = 32'd4; continuous = 1'b1;
      for (int r = 0; r < 3; r++) push_run(32'd4, 32'd0);
      gate_cnt = 0; clr_rises = 0; base = done_cnt;
      pulse_start();
      wait_done(base + 2, 600);
      continuous = 1'b0;
      wait_done(base + 3, 300);
      repeat (3) @(negedge clkin);
      chk("cont_done_pulses", 32'(done_cnt - base), 32'd3);
      chk("cont_gate_cycles", 32'(gate_cnt), 32'd12);
      chk("cont_clear_pulses", 32'(clr_rises), 32'd3);
      chk("cont_idle", 32'(busy), 32'd0);
      chk("cont_sb_empty", 32'(sb.size()), 32'd0);

      // reset mid-run clears registers and the run number
      @(posedge clkin); #1 window_len = 32'd30;
      pulse_start();
      repeat (10) @(posedge clkin);
      #1 reset = 1'b1;
      @(posedge clkin); #1 reset = 1'b0;
      @(negedge clkin);
      chk("rst_mid_busy", 32'(busy), 32'd0);
      chk("rst_mid_gate", 32'(hist_gate), 32'd0);
      chk("rst_mid_data", rd.out_data, 32'd0);
      hdr_no = '0;
      do_run('{5, 1'b1, 1'b1, 0, 32'd5, 32'd5});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got running, want finished");
      $fatal(1, "timeout");
   end

endmodule
